lc3_decode_queue: RTL and testbench
===================================

Name: lc3_decode_queue

Overview:
Parametrised successor to the single-register LC3 decode input stage. It accepts instruction words from fetch through a valid/ready handshake and buffers them in a DEPTH-entry FIFO. Control fields are pre-decoded at enqueue time and presented at the head to the execute stage through a second valid/ready handshake. A synchronous flush discards all in-flight entries on branch redirect.

Parameters:
INSTR_W, 16, instruction width; opcode is always bits [INSTR_W-1:INSTR_W-4]
ADDR_W, 16, width of npc_in / npc_out
PSR_W, 4, width of psr / psr_out
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
enable_decode  in  1  upstream valid
dout  in  INSTR_W  instruction word from fetch
npc_in  in  ADDR_W  next PC for the instruction
psr  in  PSR_W  PSR snapshot at fetch
decode_ready  out  1  upstream ready
flush  in  1  discard all queued entries
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head
ir  out  INSTR_W  head instruction
npc_out  out  ADDR_W  head next PC
psr_out  out  PSR_W  head PSR
w_en  out  1  head writes register file
w_control  out  2  writeback source select
mem_control  out  1  head needs indirect memory access
is_branch  out  1  head is BR or JMP
illegal  out  1  head opcode unsupported
count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Reset, synchronous, active-high:
  - Next edge clears wr_ptr, rd_ptr, count and all entry storage to 0.
  - Every head output reads 0; out_valid=0.
  - decode_ready is forced 0 while reset is high and becomes 1 on the first cycle after reset is released.
  - Reset mid-transfer drops all entries with no partial output.
- Enqueue: fires when enable_decode & decode_ready at a rising edge. The entry stores dout, npc_in, psr and the pre-decoded fields.
- decode_ready = (count != DEPTH) & ~reset. It is a registered-state function only; no combinational path from out_ready.
- Dequeue: fires when out_valid & out_ready. out_valid = (count != 0).
- Head outputs are combinational reads of entry[rd_ptr]. They are stable while out_valid=1 and out_ready=0.
- Enqueue and dequeue in the same cycle: count is unchanged and both pointers advance.
- Full: decode_ready=0. A simultaneous dequeue does not admit a same-cycle enqueue; decode_ready rises the next cycle.
- Empty: out_valid=0. An enqueue into an empty queue appears at the head on the following cycle, so minimum latency is 1 cycle.
- Pointers are log2(DEPTH) bits and wrap naturally.
- flush:
  - Next edge clears pointers and count.
  - Priority: reset > flush > enqueue/dequeue.
  - An enqueue or dequeue handshake in the flush cycle is discarded.
  - Storage contents are not cleared, but out_valid=0 masks them.
- Pre-decode (op = instruction[15:12]):
  - w_en=1, w_control=0 for ADD 0001, AND 0101, NOT 1001.
  - w_en=1, w_control=1 for LD 0010, LDR 0110, LDI 1010.
  - w_en=1, w_control=2 for LEA 1110.
  - Every other opcode: w_en=0, w_control=0.
  - mem_control=1 for LDI 1010 and STI 1011.
  - is_branch=1 for BR 0000 and JMP 1100.
  - illegal=1 for 1101 and RTI 1000. Illegal entries still queue and dequeue normally.

Decomposition:
- Shared package lc3_decode_pkg holds:
  - opcode localparams (OP_ADD, OP_LDI, ...);
  - the w_control encoding enum (WB_ALU=0, WB_MEM=1, WB_PC=2);
  - the packed struct decode_ctrl_t {w_en, w_control, mem_control, is_branch, illegal}.
- Sub-module lc3_predecode: purely combinational, opcode in, decode_ctrl_t out; instantiated on the enqueue path.

Test Plan:
- Reset then ADD 16'h1042, npc 16'h3001, psr 4'h2 with out_ready=1 -> next cycle out_valid=1, ir=16'h1042, npc_out=16'h3001, w_en=1, w_control=0, count=1.
- DEPTH=4, out_ready=0, push 5 words -> decode_ready falls after the 4th; 5th held by upstream; count=4; drain order matches push order.
- Full queue, enable_decode=1 and out_ready=1 same cycle -> one dequeue only, count=3, decode_ready=1 next cycle.
- Push LDI 16'hA201, STI 16'hB401, BR 16'h0E02, 16'hD000 -> mem_control 1,1,0,0; is_branch 0,0,1,0; illegal 0,0,0,1; w_control 1,0,0,0.
- Queue holding 3 entries, flush=1 with a concurrent enqueue -> next cycle count=0, out_valid=0; the concurrent word is never emitted.
- Reset asserted with 2 entries queued -> next cycle all outputs 0, decode_ready=0 until reset falls.

Source files
------------

// File: rtl/lc3_decode_pkg.sv
// Shared LC3 decode-queue definitions: opcodes, writeback select encoding and
// the pre-decoded control bundle carried alongside each queued instruction.
package lc3_decode_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_RTI = 4'b1000;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_RES = 4'b1101;
    localparam logic [3:0] OP_LEA = 4'b1110;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC  = 2'd2
    } wb_sel_e;

    typedef struct packed {
        logic    w_en;
        wb_sel_e w_control;
        logic    mem_control;
        logic    is_branch;
        logic    illegal;
    } decode_ctrl_t;

    localparam decode_ctrl_t CTRL_NONE = '{
        w_en:        1'b0,
        w_control:   WB_ALU,
        mem_control: 1'b0,
        is_branch:   1'b0,
        illegal:     1'b0
    };

endpackage

// File: rtl/lc3_predecode.sv
// Combinational opcode pre-decoder; results are stored with the instruction so
// the head of the queue needs no decode logic on the execute path.
module lc3_predecode
    import lc3_decode_pkg::*;
(
    input  logic [3:0]   op_i,
    output decode_ctrl_t ctrl_o
);

    always_comb begin
        ctrl_o = CTRL_NONE;
        case (op_i)
            OP_ADD, OP_AND, OP_NOT: begin
                ctrl_o.w_en      = 1'b1;
                ctrl_o.w_control = WB_ALU;
            end
            OP_LD, OP_LDR, OP_LDI: begin
                ctrl_o.w_en      = 1'b1;
                ctrl_o.w_control = WB_MEM;
            end
            OP_LEA: begin
                ctrl_o.w_en      = 1'b1;
                ctrl_o.w_control = WB_PC;
            end
            default: ;
        endcase
        ctrl_o.mem_control = (op_i == OP_LDI) || (op_i == OP_STI);
        ctrl_o.is_branch   = (op_i == OP_BR) || (op_i == OP_JMP);
        ctrl_o.illegal     = (op_i == OP_RES) || (op_i == OP_RTI);
    end

endmodule

// File: rtl/lc3_decode_queue.sv
// LC3 decode input queue: DEPTH-entry FIFO between fetch and execute with
// pre-decoded control fields and a synchronous flush for branch redirects.
module lc3_decode_queue
    import lc3_decode_pkg::*;
#(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned PSR_W   = 4,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable_decode,
    input  logic [INSTR_W-1:0]         dout,
    input  logic [ADDR_W-1:0]          npc_in,
    input  logic [PSR_W-1:0]           psr,
    output logic                       decode_ready,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_W-1:0]         ir,
    output logic [ADDR_W-1:0]          npc_out,
    output logic [PSR_W-1:0]           psr_out,
    output logic                       w_en,
    output logic [1:0]                 w_control,
    output logic                       mem_control,
    output logic                       is_branch,
    output logic                       illegal,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [INSTR_W-1:0] ir_q   [DEPTH];
    logic [ADDR_W-1:0]  npc_q  [DEPTH];
    logic [PSR_W-1:0]   psr_q  [DEPTH];
    decode_ctrl_t       ctrl_q [DEPTH];

    decode_ctrl_t ctrl_in;
    decode_ctrl_t ctrl_head;
    logic         push;
    logic         pop;

    lc3_predecode u_predecode (
        .op_i   (dout[INSTR_W-1 -: 4]),
        .ctrl_o (ctrl_in)
    );

    // Ready depends only on stored occupancy, never on out_ready.
    assign decode_ready = (count_q != CNT_W'(DEPTH)) & ~reset;
    assign out_valid    = (count_q != '0);
    assign push         = enable_decode & decode_ready & ~flush;
    assign pop          = out_valid & out_ready & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop) count_d = count_q + CNT_W'(1);
            if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ir_q[i]   <= '0;
                npc_q[i]  <= '0;
                psr_q[i]  <= '0;
                ctrl_q[i] <= CTRL_NONE;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                ir_q[wr_ptr_q]   <= dout;
                npc_q[wr_ptr_q]  <= npc_in;
                psr_q[wr_ptr_q]  <= psr;
                ctrl_q[wr_ptr_q] <= ctrl_in;
            end
        end
    end

    assign ctrl_head   = ctrl_q[rd_ptr_q];
    assign ir          = ir_q[rd_ptr_q];
    assign npc_out     = npc_q[rd_ptr_q];
    assign psr_out     = psr_q[rd_ptr_q];
    assign w_en        = ctrl_head.w_en;
    assign w_control   = ctrl_head.w_control;
    assign mem_control = ctrl_head.mem_control;
    assign is_branch   = ctrl_head.is_branch;
    assign illegal     = ctrl_head.illegal;
    assign count       = count_q;

endmodule

// File: tb/tb_lc3_decode_queue.sv
// Bench for lc3_decode_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_lc3_decode_queue;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset, enable_decode, flush, out_ready;
    logic [15:0] dout, npc_in;
    logic [3:0]  psr;
    logic        decode_ready, out_valid, w_en, mem_control, is_branch, illegal;
    logic [15:0] ir, npc_out;
    logic [3:0]  psr_out;
    logic [1:0]  w_control;
    logic [2:0]  count;

    lc3_decode_queue #(
        .INSTR_W (16),
        .ADDR_W  (16),
        .PSR_W   (4),
        .DEPTH   (DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable_decode (enable_decode),
        .dout          (dout),
        .npc_in        (npc_in),
        .psr           (psr),
        .decode_ready  (decode_ready),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ir            (ir),
        .npc_out       (npc_out),
        .psr_out       (psr_out),
        .w_en          (w_en),
        .w_control     (w_control),
        .mem_control   (mem_control),
        .is_branch     (is_branch),
        .illegal       (illegal),
        .count         (count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] npc;
        logic [3:0]  psr;
    } ent_t;

    ent_t mq[$];
    bit   zero_head = 1'b1;
    bit   run_cmp   = 1'b0;
    int   n_cmp     = 0;
    int   n_bad     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected control bundle {w_en, w_control[1:0], mem, branch, illegal} via opcode sets.
    function automatic logic [5:0] ref_dec(input logic [3:0] op);
        logic [15:0] wen_set, mem_wb_set, mem_set, br_set, ill_set;
        logic [1:0]  wc;
        wen_set    = 16'h4666;
        mem_wb_set = 16'h0444;
        mem_set    = 16'h0C00;
        br_set     = 16'h1001;
        ill_set    = 16'h2100;
        wc = mem_wb_set[op] ? 2'd1 : (op == 4'd14) ? 2'd2 : 2'd0;
        return {wen_set[op], wc, mem_set[op], br_set[op], ill_set[op]};
    endfunction

    task automatic model_update();
        int sz;
        bit do_pop, do_push;
        ent_t e;
        if (reset) begin
            mq.delete();
            zero_head = 1'b1;
        end else if (flush) begin
            mq.delete();
        end else begin
            sz      = mq.size();
            do_pop  = (sz != 0) && out_ready;
            do_push = enable_decode && (sz != DEPTH);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.ir  = dout;
                e.npc = npc_in;
                e.psr = psr;
                mq.push_back(e);
                zero_head = 1'b0;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        model_update();
        #2;
    endtask

    int          c_sz;
    ent_t        c_e;
    logic [5:0]  c_d;
    always @(negedge clock) begin
        if (run_cmp) begin
            c_sz = mq.size();
            chk("count", 64'(count), 64'(c_sz));
            chk("out_valid", 64'(out_valid), 64'(c_sz != 0));
            chk("decode_ready", 64'(decode_ready), 64'((c_sz != DEPTH) && !reset));
            if (c_sz != 0) begin
                c_e = mq[0];
                c_d = ref_dec(c_e.ir[15:12]);
                chk("ir", 64'(ir), 64'(c_e.ir));
                chk("npc_out", 64'(npc_out), 64'(c_e.npc));
                chk("psr_out", 64'(psr_out), 64'(c_e.psr));
                chk("ctrl", 64'({w_en, w_control, mem_control, is_branch, illegal}), 64'(c_d));
            end else if (zero_head) begin
                chk("head_zero", 64'({ir, npc_out, psr_out, w_en, w_control, mem_control,
                                      is_branch, illegal}), 64'(0));
            end
        end
    end

    task automatic push_word(input logic [15:0] w);
        enable_decode = 1'b1;
        dout          = w;
        npc_in        = w + 16'h0100;
        psr           = w[3:0];
        cyc();
        enable_decode = 1'b0;
    endtask

    logic [15:0] words [5];
    logic [15:0] dec_words [4];
    logic [5:0]  dec_exp [4];

    initial begin
        reset = 1'b1; flush = 1'b0; enable_decode = 1'b0; out_ready = 1'b0;
        dout = '0; npc_in = '0; psr = '0;

        // Reset and release.
        cyc();
        run_cmp = 1'b1;
        cyc();
        chk("rst_ready_low", 64'(decode_ready), 64'(0));
        chk("rst_valid_low", 64'(out_valid), 64'(0));
        reset = 1'b0;
        #1;
        chk("rst_ready_high", 64'(decode_ready), 64'(1));
        chk("rst_count", 64'(count), 64'(0));

        // Single ADD with one-cycle latency.
        out_ready = 1'b1; enable_decode = 1'b1;
        dout = 16'h1042; npc_in = 16'h3001; psr = 4'h2;
        cyc();
        enable_decode = 1'b0;
        chk("add_valid", 64'(out_valid), 64'(1));
        chk("add_ir", 64'(ir), 64'(16'h1042));
        chk("add_npc", 64'(npc_out), 64'(16'h3001));
        chk("add_wen_wctl", 64'({w_en, w_control}), 64'(3'b100));
        chk("add_count", 64'(count), 64'(1));
        cyc();

        // Fill to full, hold the 5th word, full + pop, then drain in order.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) words[i] = 16'h5000 + 16'(i * 16'h0111);
        for (int i = 0; i < 4; i++) push_word(words[i]);
        enable_decode = 1'b1; dout = words[4]; npc_in = words[4] + 16'h0100; psr = words[4][3:0];
        cyc();
        cyc();
        chk("full_count", 64'(count), 64'(4));
        chk("full_ready", 64'(decode_ready), 64'(0));
        out_ready = 1'b1;
        cyc();
        chk("fullpop_count", 64'(count), 64'(3));
        chk("fullpop_ready", 64'(decode_ready), 64'(1));
        out_ready = 1'b0;
        cyc();
        enable_decode = 1'b0;
        chk("refill_count", 64'(count), 64'(4));
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            chk("drain_ir", 64'(ir), 64'(words[k]));
            cyc();
        end
        chk("drain_empty", 64'(out_valid), 64'(0));

        // Pre-decode of memory, branch and illegal opcodes.
        out_ready = 1'b0;
        dec_words[0] = 16'hA201; dec_exp[0] = 6'b101100;
        dec_words[1] = 16'hB401; dec_exp[1] = 6'b000100;
        dec_words[2] = 16'h0E02; dec_exp[2] = 6'b000010;
        dec_words[3] = 16'hD000; dec_exp[3] = 6'b000001;
        for (int i = 0; i < 4; i++) push_word(dec_words[i]);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("predecode", 64'({w_en, w_control, mem_control, is_branch, illegal}),
                64'(dec_exp[i]));
            cyc();
        end

        // Flush with a concurrent enqueue.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word(16'h2000 + 16'(i));
        enable_decode = 1'b1; flush = 1'b1; dout = 16'h7777;
        cyc();
        enable_decode = 1'b0; flush = 1'b0;
        chk("flush_count", 64'(count), 64'(0));
        chk("flush_valid", 64'(out_valid), 64'(0));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("flush_no_emit", 64'(out_valid), 64'(0));
        end

        // Reset with entries queued.
        out_ready = 1'b0;
        push_word(16'h1234);
        push_word(16'h6789);
        reset = 1'b1;
        cyc();
        chk("rst2_head", 64'({out_valid, ir, npc_out, psr_out, w_en, w_control, mem_control,
                              is_branch, illegal, count}), 64'(0));
        chk("rst2_ready", 64'(decode_ready), 64'(0));
        cyc();
        chk("rst2_ready_hold", 64'(decode_ready), 64'(0));
        reset = 1'b0;
        #1;
        chk("rst2_ready_rel", 64'(decode_ready), 64'(1));

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom % 100) == 0;
            flush         = ($urandom % 25) == 0;
            enable_decode = ($urandom % 4) != 0;
            out_ready     = ($urandom % 3) != 0;
            dout          = 16'($urandom);
            npc_in        = 16'($urandom);
            psr           = 4'($urandom);
            cyc();
        end
        reset = 1'b0; flush = 1'b0; enable_decode = 1'b0; out_ready = 1'b1;
        repeat (6) cyc();

        run_cmp = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
